// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: mode-0 SPI master, one frame per accepted start.
// Every bus output is a register; one divider counter paces all phases.
module spi_master_ctrl #(
    parameter int DATA_LENGTH = 8,
    parameter int CLK_DIV     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DATA_LENGTH-1:0] tx_data,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_LENGTH-1:0] rx_data,
    output logic                   SCLK,
    output logic                   MOSI,
    input  logic                   MISO,
    output logic                   SS
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] XFER  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;
    localparam int HW = $clog2(2 * DATA_LENGTH);

    logic [2:0]             state;
    logic [7:0]             div;
    logic [HW-1:0]          hcnt;
    logic [DATA_LENGTH-1:0] tx_sr;
    logic [DATA_LENGTH-1:0] rx_sr;
    logic                   wrap;

    assign wrap = div == 8'(CLK_DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div     <= '0;
            hcnt    <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            SCLK    <= 1'b0;
            MOSI    <= 1'b0;
            SS      <= 1'b1;
        end else begin
            done <= 1'b0;
            if (state != IDLE)
                div <= wrap ? '0 : div + 8'd1;
            case (state)
                IDLE: if (start) begin
                    tx_sr <= tx_data;
                    hcnt  <= '0;
                    busy  <= 1'b1;
                    SS    <= 1'b0;
                    MOSI  <= tx_data[DATA_LENGTH-1];
                    state <= SETUP;
                end
                SETUP: if (wrap) state <= XFER;
                // even half-period ends in a rising edge, odd in a falling edge
                XFER: if (wrap) begin
                    SCLK <= ~SCLK;
                    hcnt <= hcnt + 1'b1;
                    if (!hcnt[0])
                        rx_sr <= {rx_sr[DATA_LENGTH-2:0], MISO};
                    else if (hcnt == HW'(2 * DATA_LENGTH - 1))
                        state <= HOLD;
                    else begin
                        tx_sr <= tx_sr << 1;
                        MOSI  <= tx_sr[DATA_LENGTH-2];
                    end
                end
                HOLD: if (wrap) begin
                    SS      <= 1'b1;
                    MOSI    <= 1'b0;
                    rx_data <= rx_sr;
                    done    <= 1'b1;
                    state   <= GAP;
                end
                GAP: if (wrap) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
